// File: rtl/bip3_core_if.sv
// Bus bundle between the bip3_core processor and its instruction ROM and
// data memory. The core uses the master modport and the memory side uses
// the slave modport.
interface bip3_core_if #(
  parameter int OPERAND_ADDRESS_WIDTH  = 11,
  parameter int INSTRUCTION_DATA_WIDTH = 16
);
  logic [INSTRUCTION_DATA_WIDTH-1:0] instruction_in;
  logic [OPERAND_ADDRESS_WIDTH-1:0]  instruction_address_out;
  logic [INSTRUCTION_DATA_WIDTH-1:0] data_in;
  logic                              data_ready_in;
  logic                              data_req_out;
  logic                              data_wr_out;
  logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_out;
  logic [INSTRUCTION_DATA_WIDTH-1:0] data_out;

  modport master (
    input  instruction_in, data_in, data_ready_in,
    output instruction_address_out, data_req_out, data_wr_out,
           data_address_out, data_out
  );

  modport slave (
    output instruction_in, data_in, data_ready_in,
    input  instruction_address_out, data_req_out, data_wr_out,
           data_address_out, data_out
  );
endinterface

// File: rtl/bip3_core.sv
// bip3_core: accumulator processor with logic/shift ops, a hardware
// return-address stack, wait-state data memory and a HALT state.
// Optional macro BIP3_STACK_GUARD_EN: stack overflow/underflow halts the
// core and raises the sticky stack_error_out instead of wrapping.
module bip3_core #(
  parameter int OPERAND_ADDRESS_WIDTH  = 11,
  parameter int INSTRUCTION_DATA_WIDTH = 16,
  parameter int STACK_DEPTH            = 4
) (
  input  logic        clock_in,
  input  logic        reset_in,
  bip3_core_if.master bus,
  output logic        halted_out,
  output logic        stack_error_out
);
  localparam int AW  = OPERAND_ADDRESS_WIDTH;
  localparam int DW  = INSTRUCTION_DATA_WIDTH;
  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW  = $clog2(STACK_DEPTH + 1);

  localparam logic [4:0] OP_HLT  = 5'h00, OP_STO  = 5'h01, OP_LD   = 5'h02, OP_LDI  = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04, OP_ADDI = 5'h05, OP_SUB  = 5'h06, OP_SUBI = 5'h07;
  localparam logic [4:0] OP_BEQ  = 5'h08, OP_BNE  = 5'h09, OP_BGT  = 5'h0A, OP_BGE  = 5'h0B;
  localparam logic [4:0] OP_BLT  = 5'h0C, OP_BLE  = 5'h0D, OP_JMP  = 5'h0E, OP_NOT  = 5'h0F;
  localparam logic [4:0] OP_AND  = 5'h10, OP_ANDI = 5'h11, OP_OR   = 5'h12, OP_ORI  = 5'h13;
  localparam logic [4:0] OP_XOR  = 5'h14, OP_XORI = 5'h15, OP_SLL  = 5'h16, OP_SRL  = 5'h17;
  localparam logic [4:0] OP_CALL = 5'h18, OP_RET  = 5'h19;

  typedef enum logic [1:0] {S_EXEC, S_MEM_WAIT, S_HALT} state_t;

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [DW-1:0]   acc_q;
  logic            z_q;
  logic            n_q;
  logic            req_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   dout_q;
  logic [4:0]      op_q;
  logic            halted_q;
  logic [AW-1:0]   stack_q [STACK_DEPTH];
  logic [SPW-1:0]  ptr_q;
  logic [CW-1:0]   cnt_q;
`ifdef BIP3_STACK_GUARD_EN
  logic            err_q;
`endif

  logic [4:0]      opcode;
  logic [AW-1:0]   operand;
  logic [DW-1:0]   imm;
  logic [AW-1:0]   pc_inc;
  logic [SPW-1:0]  ptr_inc;
  logic [SPW-1:0]  ptr_dec;
  logic            stack_full;
  logic            stack_empty;
  logic            taken;
  logic [DW-1:0]   exec_res;
  logic [DW-1:0]   mem_res;

  assign opcode      = bus.instruction_in[DW-1 -: 5];
  assign operand     = bus.instruction_in[AW-1:0];
  assign imm         = {{(DW-AW){operand[AW-1]}}, operand};
  assign pc_inc      = pc_q + AW'(1);
  assign ptr_inc     = (ptr_q == SPW'(STACK_DEPTH-1)) ? '0 : ptr_q + SPW'(1);
  assign ptr_dec     = (ptr_q == '0) ? SPW'(STACK_DEPTH-1) : ptr_q - SPW'(1);
  assign stack_full  = (cnt_q == CW'(STACK_DEPTH));
  assign stack_empty = (cnt_q == '0);

  // Shared ALU for both immediate (EXEC) and memory-operand (MEM_WAIT) forms.
  function automatic logic [DW-1:0] alu_f(input logic [4:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      OP_LD,  OP_LDI:  alu_f = b;
      OP_ADD, OP_ADDI: alu_f = a + b;
      OP_SUB, OP_SUBI: alu_f = a - b;
      OP_NOT:          alu_f = ~a;
      OP_AND, OP_ANDI: alu_f = a & b;
      OP_OR,  OP_ORI:  alu_f = a | b;
      OP_XOR, OP_XORI: alu_f = a ^ b;
      OP_SLL:          alu_f = a << b[3:0];
      OP_SRL:          alu_f = a >> b[3:0];
      default:         alu_f = a;
    endcase
  endfunction

  assign exec_res = alu_f(opcode, acc_q, imm);
  assign mem_res  = alu_f(op_q, acc_q, bus.data_in);

  // Branch condition from the flags left by the previous instruction.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = z_q;
      OP_BNE:  taken = !z_q;
      OP_BGT:  taken = !z_q && !n_q;
      OP_BGE:  taken = !n_q;
      OP_BLT:  taken = n_q;
      OP_BLE:  taken = z_q || n_q;
      default: taken = 1'b0;
    endcase
  end

  // Control FSM and datapath; every output comes straight from a register.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= S_EXEC;
      pc_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      op_q     <= OP_HLT;
      halted_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
`ifdef BIP3_STACK_GUARD_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_EXEC: begin
          case (opcode)
            OP_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              req_q   <= 1'b1;
              wr_q    <= (opcode == OP_STO);
              addr_q  <= operand;
              dout_q  <= acc_q;
              op_q    <= opcode;
              state_q <= S_MEM_WAIT;
            end
            OP_LDI, OP_ADDI, OP_SUBI, OP_NOT, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLL, OP_SRL: begin
              acc_q <= exec_res;
              z_q   <= (exec_res == '0);
              n_q   <= exec_res[DW-1];
              pc_q  <= pc_inc;
            end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
              pc_q <= taken ? operand : pc_inc;
            end
            OP_JMP: pc_q <= operand;
            OP_CALL: begin
`ifdef BIP3_STACK_GUARD_EN
              if (stack_full) begin
                err_q    <= 1'b1;
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else
`endif
              begin
                // Without the guard a full stack overwrites its oldest slot.
                stack_q[ptr_q] <= pc_inc;
                ptr_q          <= ptr_inc;
                if (!stack_full) cnt_q <= cnt_q + CW'(1);
                pc_q           <= operand;
              end
            end
            OP_RET: begin
`ifdef BIP3_STACK_GUARD_EN
              if (stack_empty) begin
                err_q    <= 1'b1;
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else
`endif
              if (stack_empty) begin
                pc_q <= '0;
              end else begin
                pc_q  <= stack_q[ptr_dec];
                ptr_q <= ptr_dec;
                cnt_q <= cnt_q - CW'(1);
              end
            end
            default: pc_q <= pc_inc;
          endcase
        end
        S_MEM_WAIT: begin
          if (bus.data_ready_in) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            pc_q    <= pc_inc;
            state_q <= S_EXEC;
            if (op_q != OP_STO) begin
              acc_q <= mem_res;
              z_q   <= (mem_res == '0);
              n_q   <= mem_res[DW-1];
            end
          end
        end
        S_HALT: halted_q <= 1'b1;
        default: state_q <= S_EXEC;
      endcase
    end
  end

  assign bus.instruction_address_out = pc_q;
  assign bus.data_req_out            = req_q;
  assign bus.data_wr_out             = wr_q;
  assign bus.data_address_out        = addr_q;
  assign bus.data_out                = dout_q;
  assign halted_out                  = halted_q;
`ifdef BIP3_STACK_GUARD_EN
  assign stack_error_out             = err_q;
`else
  assign stack_error_out             = 1'b0;
`endif
endmodule

// File: tb/tb_bip3_core.sv
// Self-checking bench for bip3_core: a ROM/RAM model with configurable wait
// states, and a scoreboard of expected memory writes.
module tb_bip3_core;
  localparam logic [4:0] HLT = 5'h00, STO = 5'h01, LD = 5'h02, LDI = 5'h03;
  localparam logic [4:0] ADD = 5'h04, ADDI = 5'h05, SUB = 5'h06, SUBI = 5'h07;
  localparam logic [4:0] BEQ = 5'h08, BLT = 5'h0C, BGT = 5'h0A, NOT_ = 5'h0F;
  localparam logic [4:0] ANDI = 5'h11, ORI = 5'h13, XORI = 5'h15, SLL = 5'h16;
  localparam logic [4:0] SRL = 5'h17, CALL = 5'h18, RET = 5'h19;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        reset_in;
  logic        halted_out;
  logic        stack_error_out;
  logic [15:0] rom  [2048];
  logic [15:0] dmem [2048];
  wr_t         exp_q[$];
  int          n_vec;
  int          n_miss;
  int          wait_cycles;
  int          wcnt;

  bip3_core_if #(.OPERAND_ADDRESS_WIDTH(11), .INSTRUCTION_DATA_WIDTH(16)) bus ();

  bip3_core #(.OPERAND_ADDRESS_WIDTH(11), .INSTRUCTION_DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
    .clock_in       (clk),
    .reset_in       (reset_in),
    .bus            (bus),
    .halted_out     (halted_out),
    .stack_error_out(stack_error_out)
  );

  assign bus.instruction_in = rom[bus.instruction_address_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opr);
    return {op, opr};
  endfunction

  // One clock; sample #1 after the edge and run the memory responder.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.data_req_out) begin
      if (wcnt >= wait_cycles) begin
        bus.data_ready_in = 1'b1;
        bus.data_in       = dmem[bus.data_address_out];
        if (bus.data_wr_out) begin
          dmem[bus.data_address_out] = bus.data_out;
          if (exp_q.size() == 0) begin
            check_value("wr_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_value("wr_addr", 32'(bus.data_address_out), 32'(e.addr));
            check_value("wr_data", 32'(bus.data_out), 32'(e.data));
          end
        end
        wcnt = 0;
      end else begin
        bus.data_ready_in = 1'b0;
        wcnt++;
      end
    end else begin
      bus.data_ready_in = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic expect_wr(input logic [10:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      rom[i]  = 16'h0000;
      dmem[i] = 16'h0000;
    end
    exp_q.delete();
  endtask

  // Reset, check the reset state, then release.
  task automatic do_reset(input string tag, input int waits);
    wait_cycles = waits;
    reset_in = 1'b1;
    step();
    step();
    check_value({tag, "_rst_pc"}, 32'(bus.instruction_address_out), 32'd0);
    check_value({tag, "_rst_req"}, 32'(bus.data_req_out), 32'd0);
    check_value({tag, "_rst_halt"}, 32'(halted_out), 32'd0);
    reset_in = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input logic [10:0] exp_pc, input int budget);
    for (int i = 0; i < budget && !halted_out; i++) step();
    check_value({tag, "_halted"}, 32'(halted_out), 32'd1);
    check_value({tag, "_pc"}, 32'(bus.instruction_address_out), 32'(exp_pc));
    check_value({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Call chain of n nested CALLs; each return landing stores a marker.
  task automatic build_calls(input int n);
    for (int l = 0; l < n; l++) begin
      rom[l*256]   = enc(CALL, 11'((l+1)*256));
      rom[l*256+1] = enc(LDI, 11'(17*(l+1)));
      rom[l*256+2] = enc(STO, 11'(80+l));
      rom[l*256+3] = (l == 0) ? enc(HLT, 11'd0) : enc(RET, 11'd0);
    end
    rom[n*256] = enc(RET, 11'd0);
  endtask

  initial begin
    int nreq;
    n_vec = 0;
    n_miss = 0;
    wcnt = 0;
    wait_cycles = 0;
    reset_in = 1'b1;
    bus.data_ready_in = 1'b0;
    bus.data_in = 16'h0000;

    // LDI 5; ADDI -3; HLT: halts at PC 2 and stays there.
    clear_mem();
    rom[0] = enc(LDI, 11'd5);
    rom[1] = enc(ADDI, 11'h7FD);
    rom[2] = enc(HLT, 11'd0);
    do_reset("t1", 0);
    check_value("t1_rst_err", 32'(stack_error_out), 32'd0);
    run_until_halt("t1", 11'd2, 50);
    step(); step(); step();
    check_value("t1_frozen_pc", 32'(bus.instruction_address_out), 32'd2);

    // Same arithmetic, flags probed by branches, ACC observed with STO.
    clear_mem();
    rom[0] = enc(LDI, 11'd5);
    rom[1] = enc(ADDI, 11'h7FD);
    rom[2] = enc(BEQ, 11'h040);
    rom[3] = enc(BLT, 11'h040);
    rom[4] = enc(BGT, 11'h006);
    rom[6] = enc(STO, 11'h030);
    rom[7] = enc(HLT, 11'd0);
    expect_wr(11'h030, 16'h0002);
    do_reset("t1b", 0);
    run_until_halt("t1b", 11'd7, 50);

    // STO with three wait states: request held stable for four cycles.
    clear_mem();
    rom[0] = enc(LDI, 11'h123);
    rom[1] = enc(STO, 11'h010);
    rom[2] = enc(HLT, 11'd0);
    expect_wr(11'h010, 16'h0123);
    do_reset("t2", 3);
    nreq = 0;
    for (int i = 0; i < 30 && !halted_out; i++) begin
      step();
      if (bus.data_req_out) begin
        nreq++;
        check_value("t2_wr", 32'(bus.data_wr_out), 32'd1);
        check_value("t2_addr", 32'(bus.data_address_out), 32'h010);
        check_value("t2_dout", 32'(bus.data_out), 32'h0123);
        check_value("t2_pc_hold", 32'(bus.instruction_address_out), 32'd1);
      end
    end
    check_value("t2_req_cycles", 32'(nreq), 32'd4);
    run_until_halt("t2", 11'd2, 10);

    // BEQ taken after LDI 7; SUBI 7, not taken after SUBI 6.
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      rom[0] = enc(LDI, 11'd7);
      rom[1] = enc(SUBI, (k == 0) ? 11'd7 : 11'd6);
      rom[2] = enc(BEQ, 11'h020);
      do_reset("t3", 0);
      run_until_halt("t3", (k == 0) ? 11'h020 : 11'd3, 50);
    end

    // Nested CALL depth 4 and matching RETURNs, with one wait state.
    clear_mem();
    build_calls(4);
    for (int l = 3; l >= 0; l--) expect_wr(11'(80+l), 16'(17*(l+1)));
    do_reset("t4", 1);
    run_until_halt("t4", 11'd3, 300);
    check_value("t4_err", 32'(stack_error_out), 32'd0);

    // Five nested CALLs: one more than the stack holds.
    clear_mem();
    build_calls(5);
`ifdef BIP3_STACK_GUARD_EN
    do_reset("t5g", 0);
    run_until_halt("t5g", 11'h400, 300);
    check_value("t5g_err", 32'(stack_error_out), 32'd1);
`else
    for (int l = 4; l >= 1; l--) expect_wr(11'(80+l), 16'(17*(l+1)));
    do_reset("t5", 0);
    for (int i = 0; i < 300 && bus.instruction_address_out != 11'h103; i++) step();
    check_value("t5_reach", 32'(bus.instruction_address_out), 32'h103);
    check_value("t5_sb_left", 32'(exp_q.size()), 32'd0);
    step();
    check_value("t5_empty_ret_pc", 32'(bus.instruction_address_out), 32'd0);
    check_value("t5_err", 32'(stack_error_out), 32'd0);
    check_value("t5_halt", 32'(halted_out), 32'd0);
`endif

    // Reset while an LD waits: request dropped, ACC cleared.
    clear_mem();
    rom[0] = enc(LDI, 11'd9);
    rom[1] = enc(LD, 11'h020);
    do_reset("t6", 10);
    step();
    step();
    check_value("t6_mid_req", 32'(bus.data_req_out), 32'd1);
    reset_in = 1'b1;
    step();
    check_value("t6_pc", 32'(bus.instruction_address_out), 32'd0);
    check_value("t6_req", 32'(bus.data_req_out), 32'd0);
    clear_mem();
    rom[0] = enc(STO, 11'h060);
    rom[1] = enc(HLT, 11'd0);
    expect_wr(11'h060, 16'h0000);
    reset_in = 1'b0;
    wait_cycles = 0;
    run_until_halt("t6", 11'd1, 50);

    // LDI sign extension then logical shift right.
    clear_mem();
    rom[0] = enc(LDI, 11'h401);
    rom[1] = enc(SRL, 11'd4);
    rom[2] = enc(STO, 11'h061);
    rom[3] = enc(BLT, 11'h010);
    rom[4] = enc(HLT, 11'd0);
    expect_wr(11'h061, 16'h0FC0);
    do_reset("t7", 0);
    run_until_halt("t7", 11'd4, 50);

    // Logic immediates, SLL and memory ADD/SUB down to zero.
    clear_mem();
    dmem[11'h070] = 16'h0041;
    dmem[11'h071] = 16'hF001;
    rom[0]  = enc(LDI, 11'h0F0);
    rom[1]  = enc(XORI, 11'h0FF);
    rom[2]  = enc(ORI, 11'h100);
    rom[3]  = enc(ANDI, 11'h7F3);
    rom[4]  = enc(NOT_, 11'd0);
    rom[5]  = enc(SLL, 11'd4);
    rom[6]  = enc(STO, 11'h062);
    rom[7]  = enc(ADD, 11'h070);
    rom[8]  = enc(STO, 11'h063);
    rom[9]  = enc(SUB, 11'h071);
    rom[10] = enc(BEQ, 11'h020);
    expect_wr(11'h062, 16'hEFC0);
    expect_wr(11'h063, 16'hF001);
    do_reset("t8", 1);
    run_until_halt("t8", 11'h020, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
